imem_program_loader: RTL and testbench

- Byte-stream boot loader that sits directly upstream of the two-phase pipelined processor core.
- Receives a length-prefixed program over a valid/ready byte interface and assembles big-endian 32-bit instruction words.
- Writes the words into instruction memory starting at address 0, holding the core halted until the load completes.
- On completion, releases the core (equivalent to HALTED=0, BRANCHED=0, PC=0), replacing hierarchical bench pokes with a real boot path.

---
 rtl/imem_program_loader.sv | 113 +++++++++++
 tb/tb_imem_program_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// imem_program_loader: length-prefixed byte-stream boot loader that fills instruction memory and releases the core.
// Optional IMEM_LOADER_HLT_STOP_EN: stop loading after writing an HLT word (adds hlt_seen).
module imem_program_loader #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
`ifdef IMEM_LOADER_HLT_STOP_EN
    output logic              hlt_seen,
`endif
    output logic [ADDR_W:0]   word_count
);
    localparam int HB = LEN_W / 8;
    localparam logic [31:0] CAP = 32'(1) << ADDR_W;
    typedef enum logic [2:0] {HDR, LOAD, WRITE, DONE, ERR} state_t;
    state_t state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] nlen;
    logic [23:0] sh;
    logic [3:0] bcnt;
    logic [ADDR_W:0] wc_next;
    logic xfer;
    logic stop;
    assign xfer = in_valid && in_ready;
    assign nlen = (len << 8) | LEN_W'(in_data);
    assign wc_next = word_count + 1'b1;
`ifdef IMEM_LOADER_HLT_STOP_EN
    logic hlt;
    assign hlt = mem_wdata == 32'hfc000000;
    assign stop = (32'(wc_next) == 32'(len)) || hlt;
`else
    assign stop = 32'(wc_next) == 32'(len);
`endif
    always_ff @(posedge clk1) begin
        if (rst) begin
            state <= HDR;
            len <= '0;
            sh <= '0;
            bcnt <= '0;
            in_ready <= 1'b1;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            cpu_hold <= 1'b1;
            load_done <= 1'b0;
            load_err <= 1'b0;
            word_count <= '0;
`ifdef IMEM_LOADER_HLT_STOP_EN
            hlt_seen <= 1'b0;
`endif
        end else begin
            case (state)
                HDR: if (xfer) begin
                    len <= nlen;
                    bcnt <= bcnt + 4'd1;
                    if (bcnt == 4'(HB - 1)) begin
                        bcnt <= '0;
                        if (nlen == '0) begin
                            state <= DONE;
                            in_ready <= 1'b0;
                            load_done <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (32'(nlen) > CAP) begin
                            state <= ERR;
                            in_ready <= 1'b0;
                            load_err <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: if (xfer) begin
                    sh <= {sh[15:0], in_data};
                    bcnt <= bcnt + 4'd1;
                    if (bcnt == 4'd3) begin
                        bcnt <= '0;
                        state <= WRITE;
                        in_ready <= 1'b0;
                        mem_we <= 1'b1;
                        mem_addr <= word_count[ADDR_W-1:0];
                        mem_wdata <= {sh, in_data};
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    word_count <= wc_next;
`ifdef IMEM_LOADER_HLT_STOP_EN
                    hlt_seen <= hlt_seen | hlt;
`endif
                    if (stop) begin
                        state <= DONE;
                        load_done <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state <= LOAD;
                        in_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: scoreboard bench; stimulus pushes expected writes, a monitor pops them on mem_we.
module tb_imem_program_loader;
    localparam int ADDR_W = 10;
    logic clk1 = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic in_ready, mem_we, cpu_hold, load_done, load_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [ADDR_W:0] word_count;
`ifdef IMEM_LOADER_HLT_STOP_EN
    logic hlt_seen;
`endif
    int errors = 0;
    int checks = 0;
    int nw = 0;
    int nb = 0;
    logic hs_last = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [41:0] q[$];
    logic [31:0] prog[9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};

    imem_program_loader #(.ADDR_W(ADDR_W), .LEN_W(16)) dut (
        .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .load_done(load_done), .load_err(load_err),
`ifdef IMEM_LOADER_HLT_STOP_EN
        .hlt_seen(hlt_seen),
`endif
        .word_count(word_count)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, a, e);
        end
    endtask

    always @(posedge clk1) begin
        hs_last = !rst && in_valid && in_ready;
        if (rst) nb = 0;
        else if (hs_last) nb++;
    end

    always @(negedge clk1) begin
        if (mem_we) begin
            nw++;
            chk("write_in_ready_low", in_ready, 0);
            chk("write_latency", hs_last && nb > 2 && (nb - 2) % 4 == 0, 1);
            if (q.size() == 0) begin
                chk("unexpected_write", {mem_addr, mem_wdata}, 42'h0);
            end else begin
                chk("write_addr_data", {mem_addr, mem_wdata}, q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        logic ok;
        int gap;
        gap = $urandom_range(0, gapmax);
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            @(posedge clk1);
            #1;
        end
        in_valid = 1'b1;
        in_data = b;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(posedge clk1);
            ok = in_ready;
        end
        #1;
        chk("byte_accept", ok, 1);
    endtask

    task automatic send_hdr(input logic [15:0] l, input int gapmax);
        send_byte(l[15:8], gapmax);
        send_byte(l[7:0], gapmax);
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gapmax);
        q.push_back({exp_addr, w});
        exp_addr++;
    endtask

    task automatic settle();
        in_valid = 1'b0;
        repeat (3) @(posedge clk1);
        #1;
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk1);
        #1;
        rst = 1'b0;
        exp_addr = '0;
        nw = 0;
        q.delete();
    endtask

    task automatic chk_status(input string n, input logic rdy, input logic hold, input logic done,
                              input logic err, input int wc);
        chk({n, "_in_ready"}, in_ready, rdy);
        chk({n, "_cpu_hold"}, cpu_hold, hold);
        chk({n, "_load_done"}, load_done, done);
        chk({n, "_load_err"}, load_err, err);
        chk({n, "_word_count"}, word_count, wc);
    endtask

    initial begin
        do_reset();
        chk_status("reset", 1, 1, 0, 0, 0);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);

        send_hdr(16'h0009, 0);
        for (int i = 0; i < 9; i++) send_word(prog[i], 0);
        settle();
        chk_status("prog9", 0, 0, 1, 0, 9);
        chk("prog9_writes", nw, 9);
`ifdef IMEM_LOADER_HLT_STOP_EN
        chk("prog9_hlt_seen", hlt_seen, 1);
`endif

        do_reset();
        send_hdr(16'h0000, 0);
        chk_status("len0", 0, 0, 1, 0, 0);
        in_valid = 1'b1;
        in_data = 8'h55;
        repeat (5) @(posedge clk1);
        #1;
        in_valid = 1'b0;
        chk_status("len0_after", 0, 0, 1, 0, 0);
        chk("len0_writes", nw, 0);

        do_reset();
        send_hdr(16'h0401, 0);
        chk_status("len_err", 0, 1, 0, 1, 0);
        in_valid = 1'b1;
        repeat (10) @(posedge clk1);
        #1;
        in_valid = 1'b0;
        chk_status("len_err_after", 0, 1, 0, 1, 0);
        chk("len_err_writes", nw, 0);

        do_reset();
        send_hdr(16'h0003, 1);
        send_word(32'hdeadbeef, 1);
        send_word(32'h01234567, 1);
        send_word(32'h89abcdef, 1);
        settle();
        chk_status("gaps", 0, 0, 1, 0, 3);
        chk("gaps_writes", nw, 3);

        do_reset();
        send_hdr(16'h0002, 0);
        send_word(32'ha5a5a5a5, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        in_valid = 1'b1;
        in_data = 8'h33;
        rst = 1'b1;
        @(posedge clk1);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        exp_addr = '0;
        repeat (6) @(posedge clk1);
        #1;
        chk_status("midrst", 1, 1, 0, 0, 0);
        chk("midrst_writes", nw, 1);
        chk("midrst_queue", q.size(), 0);
        nw = 0;
        send_hdr(16'h0002, 0);
        send_word(32'h0badf00d, 0);
        send_word(32'h12345678, 0);
        settle();
        chk_status("reload", 0, 0, 1, 0, 2);
        chk("reload_writes", nw, 2);

        do_reset();
        send_hdr(16'h0400, 0);
        for (int i = 0; i < 1024; i++) send_word({16'(i), 16'h1234}, 0);
        settle();
        chk_status("full", 0, 0, 1, 0, 1024);
        chk("full_writes", nw, 1024);
        chk("full_last_addr", mem_addr, 10'h3ff);

`ifdef IMEM_LOADER_HLT_STOP_EN
        do_reset();
        send_hdr(16'h0005, 0);
        send_word(32'h11111111, 0);
        send_word(32'hfc000000, 0);
        settle();
        in_valid = 1'b1;
        repeat (5) @(posedge clk1);
        #1;
        in_valid = 1'b0;
        chk_status("hlt", 0, 0, 1, 0, 2);
        chk("hlt_writes", nw, 2);
        chk("hlt_seen", hlt_seen, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
